// File: rtl/sym_pkg.sv
// Shared types and constants for the 2-bit symbol stream transmitter.
package sym_pkg;

  typedef enum logic [2:0] {IDLE, PRE, DATA, STALL, CHK, GAP} state_t;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_PRE  = 2'b11;

  function automatic int syms_per_word(input int word_w);
    return word_w / 2;
  endfunction

endpackage

// File: rtl/sym_stream_tx_if.sv
// Word-in / symbol-out bundle between an upstream word source and sym_stream_tx.
interface sym_stream_tx_if #(parameter int WORD_W = 8);
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic [1:0]        sym_out;
  logic              sym_valid;

  modport master (output s_valid, s_data, s_last, input  s_ready, sym_out, sym_valid);
  modport slave  (input  s_valid, s_data, s_last, output s_ready, sym_out, sym_valid);
endinterface

// File: rtl/sym_tx_shifter.sv
// Word register, symbol index, last flag and running XOR checksum.
// cur_sym is always the low pair of the shifted word.
module sym_tx_shifter import sym_pkg::*; #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              adv,
  input  logic [WORD_W-1:0] data,
  input  logic              last_in,
  output logic [1:0]        cur_sym,
  output logic              last_sym_of_word,
  output logic              last_flag,
  output logic [1:0]        checksum
);
  localparam int NSYM  = syms_per_word(WORD_W);
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;

  assign cur_sym          = sreg[1:0];
  assign last_sym_of_word = (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      idx       <= '0;
      last_flag <= 1'b0;
      checksum  <= '0;
    end else begin
      // A load on the final symbol wins over the shift, giving a bubble-free next word
      if (load) begin
        sreg      <= data;
        idx       <= '0;
        last_flag <= last_in;
      end else if (adv) begin
        sreg <= sreg >> 2;
        idx  <= last_sym_of_word ? '0 : idx + 1'b1;
      end
      if (clr)
        checksum <= '0;
      else if (adv)
        checksum <= checksum ^ cur_sym;
    end
  end

endmodule

// File: rtl/sym_stream_tx.sv
// Frames words into 2-bit symbols: preamble, data (LSB pair first), XOR checksum, gap.
// Symbol outputs are registered, so they lag the FSM state by one cycle.
module sym_stream_tx import sym_pkg::*; #(
  parameter int         WORD_W   = 8,
  parameter int         PRE_LEN  = 2,
  parameter logic [1:0] PRE_SYM  = SYM_PRE,
  parameter logic [1:0] IDLE_SYM = SYM_IDLE,
  parameter int         GAP_LEN  = 1,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  sym_stream_tx_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int CMAX = (PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    sym_q, sym_d;
  logic          vld_q, vld_d;
  logic          cnt_inc;
  logic          ready, xfer, adv;
  logic [1:0]    cur_sym, checksum;
  logic          last_sym, last_flag;

  // Ready depends only on state and shifter position, never on s_valid
  assign ready = (state == IDLE) || (state == STALL) ||
                 ((state == DATA) && last_sym && !last_flag);
  assign xfer  = bus.s_valid && ready;
  assign adv   = (state == DATA);
  assign busy  = (state != IDLE);

  assign bus.s_ready   = ready;
  assign bus.sym_out   = sym_q;
  assign bus.sym_valid = vld_q;

  sym_tx_shifter #(.WORD_W(WORD_W)) u_shift (
    .clk              (clk),
    .rst              (rst),
    .load             (xfer),
    .clr              (xfer && (state == IDLE)),
    .adv              (adv),
    .data             (bus.s_data),
    .last_in          (bus.s_last),
    .cur_sym          (cur_sym),
    .last_sym_of_word (last_sym),
    .last_flag        (last_flag),
    .checksum         (checksum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sym_q     <= IDLE_SYM;
      vld_q     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sym_q <= sym_d;
      vld_q <= vld_d;
      if (cnt_inc)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sym_d   = IDLE_SYM;
    vld_d   = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        sym_d = PRE_SYM;
        vld_d = 1'b1;
        if (cnt == PRE_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        sym_d = cur_sym;
        vld_d = 1'b1;
        if (last_sym) begin
          if (last_flag)
            state_d = CHK;
          else if (!xfer)
            state_d = STALL;
        end
      end
      STALL: begin
        if (xfer)
          state_d = DATA;
      end
      CHK: begin
        // checksum already includes the final data symbol folded in on the last DATA edge
        sym_d   = checksum;
        vld_d   = 1'b1;
        cnt_inc = 1'b1;
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sym_stream_tx.sv
// Directed bench for sym_stream_tx: stimulus pushes hand-computed symbols, a monitor pops and compares.
module tb_sym_stream_tx;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  sym_stream_tx_if #(.WORD_W(8)) bus();

  sym_stream_tx #(
    .WORD_W(8), .PRE_LEN(2), .PRE_SYM(2'b11), .IDLE_SYM(2'b00), .GAP_LEN(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       sym;
    logic             is_chk;
    int               gap;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_frames = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // gap = -1 means the preceding idle cycles are not checked
  task automatic push_sym(input logic [1:0] s, input int gap, input logic is_chk);
    exp_t e;
    e.sym = s; e.gap = gap; e.is_chk = is_chk; e.cnt = CNT_W'(exp_frames);
    q.push_back(e);
  endtask

  task automatic push_pre();
    push_sym(2'b11, -1, 1'b0);
    push_sym(2'b11, 0, 1'b0);
  endtask

  task automatic push_word(input logic [7:0] w, input int gap0);
    for (int i = 0; i < 4; i++)
      push_sym(w[2*i +: 2], (i == 0) ? gap0 : 0, 1'b0);
  endtask

  task automatic push_chk(input logic [1:0] c);
    exp_frames = (exp_frames + 1) % 16;
    push_sym(c, 0, 1'b1);
  endtask

  // Called in the low clock phase; returns at the negedge after the accepting edge.
  task automatic tx_word(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    while (!bus.s_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin : monitor
    bit   in_frame;
    int   gapc;
    exp_t e;
    in_frame = 1'b0;
    gapc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        in_frame = 1'b0;
        gapc = 0;
      end else if (bus.sym_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_sym: got %0h expected none at %0t", bus.sym_out, $time);
        end else begin
          e = q.pop_front();
          check("sym", 32'(bus.sym_out), 32'(e.sym));
          if (e.gap >= 0) check("gap_cycles", 32'(gapc), 32'(e.gap));
          if (e.is_chk) check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
          in_frame = !e.is_chk;
          gapc = 0;
        end
      end else if (in_frame) begin
        gapc++;
        check("stall_sym", 32'(bus.sym_out), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc;
    int acc;
    logic [7:0] w;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("rst_sym_out",   32'(bus.sym_out),   32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_frame_cnt", 32'(frame_cnt),     32'd0);
    check("rst_s_ready",   32'(bus.s_ready),   32'd1);
    rst = 1'b0;
    @(negedge clk);

    // single word 0xB4: 00,01,11,10 checksum 00
    push_pre(); push_word(8'hB4, 0); push_chk(2'b00);
    tx_word(8'hB4, 1'b1);
    wait_idle(cyc);
    check("busy_len", 32'(cyc), 32'd8);

    // 0x0F then 0xF0 back to back
    push_pre(); push_word(8'h0F, 0); push_word(8'hF0, 0); push_chk(2'b00);
    tx_word(8'h0F, 1'b0);
    tx_word(8'hF0, 1'b1);
    wait_idle(cyc);

    // same frame with the second word 3 cycles late
    push_pre(); push_word(8'h0F, 0); push_word(8'hF0, 3); push_chk(2'b00);
    tx_word(8'h0F, 1'b0);
    cyc = 0;
    while (!bus.s_ready && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 32'(bus.s_ready), 32'd1);
      check("stall_busy",  32'(busy),        32'd1);
    end
    tx_word(8'hF0, 1'b1);
    wait_idle(cyc);

    // reset while the second data symbol is on the output
    push_pre(); push_word(8'hB4, 0); push_chk(2'b00);
    tx_word(8'hB4, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt),     32'd0);
    check("midrst_s_ready",   32'(bus.s_ready),   32'd1);
    check("midrst_busy",      32'(busy),          32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_frames = 0;
    @(negedge clk);
    // 0x07: 11,01,00,00 checksum 10
    push_pre(); push_word(8'h07, 0); push_chk(2'b10);
    tx_word(8'h07, 1'b1);

    // 15 more frames: count runs 2..15 then wraps to 0
    for (int i = 1; i < 16; i++) begin
      w = (i % 2) ? 8'hB4 : 8'h07;
      push_pre(); push_word(w, 0); push_chk((i % 2) ? 2'b00 : 2'b10);
      tx_word(w, 1'b1);
    end
    wait_idle(cyc);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    // s_valid held high with junk data while not ready
    acc = 0;
    cyc = 0;
    bus.s_valid = 1'b1;
    while (acc < 2 && cyc < 200) begin
      if (bus.s_ready) begin
        w = (acc == 0) ? 8'h07 : 8'hB4;
        bus.s_data = w;
        bus.s_last = 1'b1;
        push_pre(); push_word(w, 0); push_chk((acc == 0) ? 2'b10 : 2'b00);
        acc++;
      end else begin
        bus.s_data = 8'($urandom);
        bus.s_last = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    check("held_valid_accepts", 32'(acc), 32'd2);
    wait_idle(cyc);
    check("final_frame_cnt", 32'(frame_cnt), 32'd2);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
